// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request/response and memory-side bundles of the load/store unit
// Request side: the datapath is master. Memory side: the unit is master.

interface lsu_req_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [63:0]           req_wdata;
  logic                  resp_valid;
  logic [63:0]           resp_rdata;
  logic                  resp_fault;

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_fault
  );

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_fault
  );
endinterface

interface lsu_mem_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_endereco;
  logic [63:0]           mem_write_data;
  logic [63:0]           mem_read_data;

  modport master (
    output mem_read, mem_write, mem_endereco, mem_write_data,
    input  mem_read_data
  );

  modport slave (
    input  mem_read, mem_write, mem_endereco, mem_write_data,
    output mem_read_data
  );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - load/store sequencer over aligned big-endian 8-byte memory windows
// Sub-doubleword stores are read-modify-write; loads are extended by funct3.

module load_store_unit #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  lsu_req_if.slave   req,
  lsu_mem_if.master  mem
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_READ,
    S_WRITE,
    S_RESP
  } state_t;

  state_t                r_state;
  state_t                w_next;

  logic [2:0]            r_funct3;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [63:0]           r_wdata;
  logic [63:0]           r_merged;
  logic [63:0]           r_rdata;
  logic                  r_fault;

  logic                  w_req_fault;
  logic                  w_misaligned;
  logic [5:0]            w_shift;
  logic [63:0]           w_aligned;
  logic [63:0]           w_load_ext;
  logic                  w_sx;
  logic [63:0]           w_field_top;
  logic [63:0]           w_mask_top;
  logic [63:0]           w_field;
  logic [63:0]           w_mask;
  logic [63:0]           w_merge;

  logic                  w_mem_read;
  logic                  w_mem_write;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [63:0]           w_mem_wdata;

  always_comb begin
    w_misaligned = 1'b0;
    case (req.req_funct3[1:0])
      2'b00:   w_misaligned = 1'b0;
      2'b01:   w_misaligned = req.req_addr[0];
      2'b10:   w_misaligned = |req.req_addr[1:0];
      default: w_misaligned = |req.req_addr[2:0];
    endcase
    w_req_fault = (req.req_funct3 == 3'b111)
                | (req.req_write & req.req_funct3[2])
                | w_misaligned;
  end

  // Shifting the window left by the lane offset puts the addressed byte at [63:56].
  assign w_shift   = {r_addr[2:0], 3'b000};
  assign w_aligned = mem.mem_read_data << w_shift;
  assign w_sx      = ~r_funct3[2];

  always_comb begin
    w_load_ext = w_aligned;
    case (r_funct3[1:0])
      2'b00:   w_load_ext = {{56{w_sx & w_aligned[63]}}, w_aligned[63:56]};
      2'b01:   w_load_ext = {{48{w_sx & w_aligned[63]}}, w_aligned[63:48]};
      2'b10:   w_load_ext = {{32{w_sx & w_aligned[63]}}, w_aligned[63:32]};
      default: w_load_ext = w_aligned;
    endcase
  end

  always_comb begin
    w_field_top = r_wdata;
    w_mask_top  = {64{1'b1}};
    case (r_funct3[1:0])
      2'b00: begin
        w_field_top = {r_wdata[7:0], 56'd0};
        w_mask_top  = {8'hFF, 56'd0};
      end
      2'b01: begin
        w_field_top = {r_wdata[15:0], 48'd0};
        w_mask_top  = {16'hFFFF, 48'd0};
      end
      2'b10: begin
        w_field_top = {r_wdata[31:0], 32'd0};
        w_mask_top  = {32'hFFFF_FFFF, 32'd0};
      end
      default: begin
        w_field_top = r_wdata;
        w_mask_top  = {64{1'b1}};
      end
    endcase
  end

  assign w_field = w_field_top >> w_shift;
  assign w_mask  = w_mask_top >> w_shift;
  assign w_merge = (mem.mem_read_data & ~w_mask) | (w_field & w_mask);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (req.req_valid) begin
          if (w_req_fault)                     w_next = S_RESP;
          else if (!req.req_write)             w_next = S_LOAD;
          else if (req.req_funct3[1:0] == 2'b11) w_next = S_WRITE;
          else                                 w_next = S_READ;
        end
      end
      S_LOAD:  w_next = S_RESP;
      S_READ:  w_next = S_WRITE;
      S_WRITE: w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Memory strobes come straight from the state so an async reset drops them at once.
  always_comb begin
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = 64'd0;
    case (r_state)
      S_LOAD, S_READ: begin
        w_mem_read = 1'b1;
        w_mem_addr = {r_addr[ADDR_WIDTH-1:3], 3'b000};
      end
      S_WRITE: begin
        w_mem_write = 1'b1;
        w_mem_addr  = {r_addr[ADDR_WIDTH-1:3], 3'b000};
        w_mem_wdata = (r_funct3[1:0] == 2'b11) ? r_wdata : r_merged;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_funct3 <= 3'd0;
      r_addr   <= '0;
      r_wdata  <= 64'd0;
      r_merged <= 64'd0;
      r_rdata  <= 64'd0;
      r_fault  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req.req_valid) begin
            r_funct3 <= req.req_funct3;
            r_addr   <= req.req_addr;
            r_wdata  <= req.req_wdata;
            if (w_req_fault) begin
              r_rdata <= 64'd0;
              r_fault <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          r_rdata <= w_load_ext;
          r_fault <= 1'b0;
        end
        S_READ: r_merged <= w_merge;
        S_WRITE: begin
          r_rdata <= 64'd0;
          r_fault <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign req.req_ready      = (r_state == S_IDLE);
  assign req.resp_valid     = (r_state == S_RESP);
  assign req.resp_rdata     = r_rdata;
  assign req.resp_fault     = r_fault;
  assign mem.mem_read       = w_mem_read;
  assign mem.mem_write      = w_mem_write;
  assign mem.mem_endereco   = w_mem_addr;
  assign mem.mem_write_data = w_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - bench for load_store_unit with a byte-array memory and reference model

module tb_load_store_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lsu_req_if #(.ADDR_WIDTH(8)) req ();
  lsu_mem_if #(.ADDR_WIDTH(8)) mem ();

  load_store_unit #(.ADDR_WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .mem   (mem)
  );

  logic [7:0] phys  [256];
  logic [7:0] model [256];
  int vectors     = 0;
  int miscompares = 0;

  logic [4:0] w_blk;
  assign w_blk = mem.mem_endereco[7:3];
  assign mem.mem_read_data = {phys[{w_blk, 3'd0}], phys[{w_blk, 3'd1}], phys[{w_blk, 3'd2}],
                              phys[{w_blk, 3'd3}], phys[{w_blk, 3'd4}], phys[{w_blk, 3'd5}],
                              phys[{w_blk, 3'd6}], phys[{w_blk, 3'd7}]};

  always @(negedge clk) begin
    if (mem.mem_write) begin
      for (int i = 0; i < 8; i++)
        phys[{w_blk, 3'(i)}] = mem.mem_write_data[63-8*i -: 8];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: byte-level view of memory, big-endian field of 2**funct3[1:0] bytes.
  task automatic model_op(input logic w, input logic [2:0] f3, input logic [7:0] a,
                          input logic [63:0] wd, output logic [63:0] erd,
                          output logic eflt, output int elat);
    int n;
    logic [63:0] v;
    n    = 1 << f3[1:0];
    eflt = (f3 == 3'b111) || (w && f3[2]) || ((int'(a) % n) != 0);
    erd  = 64'd0;
    if (eflt) begin
      elat = 1;
    end else if (!w) begin
      v = 64'd0;
      for (int i = 0; i < n; i++) v = (v << 8) | 64'(model[int'(a) + i]);
      if (!f3[2] && n < 8 && v[8*n-1]) v = v - (64'd1 << (8*n));
      erd  = v;
      elat = 2;
    end else begin
      for (int i = 0; i < n; i++) model[int'(a) + i] = 8'(wd >> (8*(n-1-i)));
      elat = (n == 8) ? 2 : 3;
    end
  endtask

  task automatic issue(input logic w, input logic [2:0] f3, input logic [7:0] a,
                       input logic [63:0] wd, output logic [63:0] rd, output logic flt,
                       output int lat, output int rc, output int wc, output logic aok);
    int budget;
    @(negedge clk);
    req.req_valid  = 1'b1;
    req.req_write  = w;
    req.req_funct3 = f3;
    req.req_addr   = a;
    req.req_wdata  = wd;
    budget = 0;
    while (!req.req_ready && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    @(posedge clk);
    #1 req.req_valid = 1'b0;
    lat = 0; rc = 0; wc = 0; aok = 1'b1; rd = 'x; flt = 1'bx;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (mem.mem_read && rc == 0)  rc = lat;
      if (mem.mem_write && wc == 0) wc = lat;
      if ((mem.mem_read || mem.mem_write) && mem.mem_endereco !== (a & 8'hF8)) aok = 1'b0;
      if (req.resp_valid) begin
        rd  = req.resp_rdata;
        flt = req.resp_fault;
        break;
      end
    end
  endtask

  task automatic run(input string tag, input logic w, input logic [2:0] f3, input logic [7:0] a,
                     input logic [63:0] wd, output logic [63:0] rd);
    logic [63:0] erd;
    logic eflt, flt, aok;
    int elat, lat, rc, wc, erc, ewc, n;
    n = 1 << f3[1:0];
    model_op(w, f3, a, wd, erd, eflt, elat);
    issue(w, f3, a, wd, rd, flt, lat, rc, wc, aok);
    erc = (!eflt && (!w || n < 8)) ? 1 : 0;
    ewc = (eflt || !w) ? 0 : ((n == 8) ? 1 : 2);
    check({tag, "_rdata"}, rd, erd);
    check({tag, "_fault"}, 64'(flt), 64'(eflt));
    check({tag, "_latency"}, 64'(lat), 64'(elat));
    check({tag, "_rd_cycle"}, 64'(rc), 64'(erc));
    check({tag, "_wr_cycle"}, 64'(wc), 64'(ewc));
    check({tag, "_base"}, 64'(aok), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 64'(req.req_ready), 64'd1);
    check({tag, "_resp_valid"}, 64'(req.resp_valid), 64'd0);
    check({tag, "_resp_fault"}, 64'(req.resp_fault), 64'd0);
    check({tag, "_resp_rdata"}, req.resp_rdata, 64'd0);
    check({tag, "_mem_read"}, 64'(mem.mem_read), 64'd0);
    check({tag, "_mem_write"}, 64'(mem.mem_write), 64'd0);
    check({tag, "_mem_addr"}, 64'(mem.mem_endereco), 64'd0);
    check({tag, "_mem_wdata"}, mem.mem_write_data, 64'd0);
  endtask

  initial begin
    logic [63:0] rd, erd, e0, e1, wd;
    logic eflt;
    int elat, pulses, nacc, n;
    int pcyc [2];
    logic [63:0] pdat [2];
    logic acc_now, w;
    logic [2:0] f3;
    logic [7:0] a;

    for (int i = 0; i < 256; i++) phys[i] = (i >= 24) ? 8'($urandom) : 8'd0;
    phys[7]  = 8'h08;
    phys[15] = 8'h06;
    for (int i = 0; i < 256; i++) model[i] = phys[i];

    req.req_valid = 1'b0; req.req_write = 1'b0; req.req_funct3 = 3'd0;
    req.req_addr = 8'd0; req.req_wdata = 64'd0;
    reset = 1'b1;
    #1 check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    run("ld0", 1'b0, 3'b011, 8'd0, 64'd0, rd);
    check("ld0_const", rd, 64'h0000_0000_0000_0008);
    run("sb9", 1'b1, 3'b000, 8'd9, 64'h80, rd);
    run("lb9", 1'b0, 3'b000, 8'd9, 64'd0, rd);
    check("lb9_const", rd, 64'hFFFF_FFFF_FFFF_FF80);
    run("lbu9", 1'b0, 3'b100, 8'd9, 64'd0, rd);
    check("lbu9_const", rd, 64'h0000_0000_0000_0080);
    run("ld8", 1'b0, 3'b011, 8'd8, 64'd0, rd);
    check("ld8_const", rd, 64'h0080_0000_0000_0006);
    run("sw20", 1'b1, 3'b010, 8'd20, 64'hDEAD_BEEF, rd);
    run("ld16", 1'b0, 3'b011, 8'd16, 64'd0, rd);
    check("ld16_const", rd, 64'h0000_0000_DEAD_BEEF);
    run("lw20", 1'b0, 3'b010, 8'd20, 64'd0, rd);
    check("lw20_const", rd, 64'hFFFF_FFFF_DEAD_BEEF);
    run("lh3", 1'b0, 3'b001, 8'd3, 64'd0, rd);
    run("sb_f100", 1'b1, 3'b100, 8'd9, 64'h55, rd);

    // SH aborted in READ: no write may land.
    @(negedge clk);
    req.req_valid = 1'b1; req.req_write = 1'b1; req.req_funct3 = 3'b001;
    req.req_addr = 8'd0; req.req_wdata = 64'hABCD;
    @(posedge clk);
    #1 req.req_valid = 1'b0;
    check("sh_abort_in_read", 64'(mem.mem_read), 64'd1);
    #1 reset = 1'b1;
    #1 check_reset_outputs("abort_read");
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    #1 check("abort_read_ready", 64'(req.req_ready), 64'd1);
    run("ld0_after_abort", 1'b0, 3'b011, 8'd0, 64'd0, rd);
    check("ld0_after_abort_const", rd, 64'h0000_0000_0000_0008);

    // SW aborted in WRITE before the falling edge: suppressed.
    @(negedge clk);
    req.req_valid = 1'b1; req.req_write = 1'b1; req.req_funct3 = 3'b010;
    req.req_addr = 8'd0; req.req_wdata = 64'h1234_5678;
    @(posedge clk);
    #1 req.req_valid = 1'b0;
    @(posedge clk);
    #1 check("sw_in_write", 64'(mem.mem_write), 64'd1);
    reset = 1'b1;
    #1 check("sw_write_dropped", 64'(mem.mem_write), 64'd0);
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    run("ld0_after_wr_abort", 1'b0, 3'b011, 8'd0, 64'd0, rd);

    // SD aborted in WRITE after the falling edge: the write stands.
    wd = {$urandom, $urandom};
    @(negedge clk);
    req.req_valid = 1'b1; req.req_write = 1'b1; req.req_funct3 = 3'b011;
    req.req_addr = 8'd24; req.req_wdata = wd;
    @(posedge clk);
    #1 req.req_valid = 1'b0;
    @(negedge clk);
    #1 reset = 1'b1;
    model_op(1'b1, 3'b011, 8'd24, wd, erd, eflt, elat);
    #1 check("sd_late_abort_no_resp", 64'(req.resp_valid), 64'd0);
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    run("ld24_after_late_abort", 1'b0, 3'b011, 8'd24, 64'd0, rd);
    check("ld24_const", rd, wd);

    // Two loads queued behind a held-high req_valid.
    model_op(1'b0, 3'b011, 8'd0, 64'd0, e0, eflt, elat);
    model_op(1'b0, 3'b011, 8'd8, 64'd0, e1, eflt, elat);
    pulses = 0; nacc = 0; pcyc[0] = 0; pcyc[1] = 0; pdat[0] = 'x; pdat[1] = 'x;
    @(negedge clk);
    req.req_valid = 1'b1; req.req_write = 1'b0; req.req_funct3 = 3'b011; req.req_addr = 8'd0;
    for (int c = 0; c < 16; c++) begin
      if (req.resp_valid) begin
        if (pulses < 2) begin
          pcyc[pulses] = c;
          pdat[pulses] = req.resp_rdata;
        end
        pulses++;
      end
      acc_now = req.req_valid && req.req_ready;
      @(posedge clk);
      #1;
      if (acc_now) begin
        nacc++;
        if (nacc == 1) req.req_addr = 8'd8;
        else           req.req_valid = 1'b0;
      end
      @(negedge clk);
    end
    check("b2b_pulses", 64'(pulses), 64'd2);
    check("b2b_spacing", 64'(pcyc[1] - pcyc[0]), 64'd3);
    check("b2b_first", pdat[0], e0);
    check("b2b_second", pdat[1], e1);
    check("b2b_first_const", pdat[0], 64'h8);

    for (int k = 0; k < 150; k++) begin
      w  = 1'($urandom);
      f3 = 3'($urandom_range(0, 7));
      n  = 1 << f3[1:0];
      a  = 8'($urandom);
      if ($urandom_range(0, 3) != 0) a = a & ~8'(n - 1);
      wd = {$urandom, $urandom};
      run("rand", w, f3, a, wd, rd);
    end

    for (int k = 0; k < 32; k++) begin
      e0 = 64'd0; e1 = 64'd0;
      for (int i = 0; i < 8; i++) begin
        e0 = (e0 << 8) | 64'(phys[8*k + i]);
        e1 = (e1 << 8) | 64'(model[8*k + i]);
      end
      check("final_mem", e0, e1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store sequencer between the datapath and the byte-addressed, big-endian 256-byte `data_memory`. It accepts one load or store request at a time over a valid/ready handshake and always drives the memory with naturally aligned 8-byte windows. Stores narrower than 64 bits are done as read-modify-write. Load results are sign- or zero-extended by RISC-V `funct3` and returned with a one-cycle response pulse.

## Interface
- `ADDR_WIDTH`, 8: byte-address width; matches the 256-byte data memory.
- `clk`  in  1  single clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept; high only in IDLE.
- `req_write`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV64 width code: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
- `req_addr`  in  ADDR_WIDTH  byte address (ALU result).
- `req_wdata`  in  64  store data (rs2); the low bytes are used.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  64  extended load data; 0 for stores and faults.
- `resp_fault`  out  1  misaligned address or illegal `funct3`; qualified by `resp_valid`.
- `mem_read`  out  1  memory read strobe.
- `mem_write`  out  1  memory write strobe; memory commits on the falling edge of `clk` in that cycle.
- `mem_endereco`  out  ADDR_WIDTH  window base, always `req_addr & ~7`.
- `mem_write_data`  out  64  merged doubleword.
- `mem_read_data`  in  64  combinational read; byte at `base+0` is in bits [63:56].

## Operation
- Lane offset `off = addr[2:0]`. The byte at `addr` occupies `mem_read_data[63-8*off -: 8]`. A half, word or doubleword occupies the next 2/4/8 lower-order bytes.
- Alignment rules: H needs `addr[0]=0`, W needs `addr[1:0]=0`, D needs `addr[2:0]=0`. Because every window is aligned, no window can run past byte 255.
- Illegal `funct3` values:
  - 111 for any request.
  - 1xx for a store.
- A fault (misaligned or illegal) performs no memory access. The response carries `resp_fault=1` and `resp_rdata=0`.
- Extension: B/H/W are sign-extended; BU/HU/WU are zero-extended.
- Store merge: the lanes selected by `off` and the access size take `req_wdata` (low-order bytes, big-endian within the field). All other lanes keep their previously read values.
- Request fields are latched in the IDLE cycle in which `req_valid & req_ready` is true.
- FSM states and transitions:
  - IDLE: on `req_valid`, go to RESP if faulting; LOAD for a load; WRITE for a 64-bit store; READ for a narrower store.
  - LOAD: assert `mem_read`; register the extracted, extended data; go to RESP.
  - READ: assert `mem_read`; register the merged doubleword; go to WRITE.
  - WRITE: assert `mem_write` and drive the merged data (or `req_wdata` for a D store); go to RESP.
  - RESP: `resp_valid=1`; go to IDLE.
- Memory-side outputs are decoded from the state. Outside LOAD, READ and WRITE they are all 0.

## Timing
- Reset values (applied asynchronously): state IDLE, `req_ready=1`, `resp_valid=0`, `resp_fault=0`, `resp_rdata=0`, `mem_read=0`, `mem_write=0`, `mem_endereco=0`, `mem_write_data=0`.
- Latency from the accept cycle to the `resp_valid` cycle:
  - Load: 2 cycles.
  - 64-bit store: 2 cycles.
  - Sub-doubleword store: 3 cycles.
  - Fault: 1 cycle.
- Back-to-back requests: the next request is accepted no sooner than the cycle after RESP. `req_valid` held high across RESP is not accepted until IDLE.
- `resp_rdata` and `resp_fault` hold their values until the next response.
- Reset during LOAD or READ: no memory update occurs.
- Reset during WRITE:
  - Asserted before the falling edge: `mem_write` drops immediately and the write is suppressed.
  - Asserted after the falling edge: the memory update stands; there is no rollback.
- In any of these cases no response is issued for the aborted request.

## Test plan
- LD 0x00, fresh memory → `resp_valid` 2 cycles after accept; `resp_rdata=0x0000000000000008`; `resp_fault=0`.
- SB addr 9, wdata `0x80` → `mem_read` at cycle 1, `mem_write` at cycle 2 with base 8.
  - Then LB 9 → `0xFFFFFFFFFFFFFF80`.
  - LBU 9 → `0x0000000000000080`.
  - LD 8 → `0x0080000000000006` (byte 15 preserved).
- SW addr 20, wdata `0xDEADBEEF` → then LD 16 returns `0x00000000DEADBEEF`; LW 20 returns `0xFFFFFFFFDEADBEEF`.
- LH addr 3, and SB with `funct3=100` → each gives `resp_fault=1` and `resp_rdata=0` one cycle after accept; `mem_read` and `mem_write` never assert.
- SH addr 0 interrupted: assert `reset` during READ → all outputs return to reset values in the same cycle; a later LD 0 returns `0x...08`; `req_ready=1` after release.
- `req_valid` held high with two queued loads (LD 0, LD 8) → exactly two `resp_valid` pulses, 3 cycles apart, returning `0x...08` then `0x...06`.
